// File: rtl/nor_gate_exerciser_if.sv
// nor_gate_exerciser_if
//   Bundles the run-control inputs, the cell-under-test connections and the
//   result outputs of nor_gate_exerciser.
//   Signals:
//     start, continuous : run requests from the controller
//     y                 : output of the NOR cell under test
//     a, b              : registered NOR inputs driven towards the cell
//     busy, done, pass  : run status / result
//     err_cnt, run_cnt  : saturating mismatch count, wrapping run count
//     vec_idx           : index of the vector currently applied
//   Modports: slave = the exerciser, master = whoever controls/observes it.
interface nor_gate_exerciser_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             continuous;
    logic             y;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [1:0]       vec_idx;

    modport slave (
        input  start, continuous, y,
        output a, b, busy, done, pass, err_cnt, run_cnt, vec_idx
    );

    modport master (
        output start, continuous, y,
        input  a, b, busy, done, pass, err_cnt, run_cnt, vec_idx
    );
endinterface

// File: rtl/nor_gate_exerciser.sv
// nor_gate_exerciser
//   Drives the four input combinations of a 2-input NOR cell, holds each for
//   SETTLE_CYCLES clocks, samples the cell output once and compares it with
//   ~(a|b). Reports a per-run pass flag, a saturating mismatch count and a
//   wrapping run count. Optional continuous mode re-launches runs back to back
//   while accumulating err_cnt.
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : nor_gate_exerciser_if.slave (start/continuous/y in,
//             a/b/busy/done/pass/err_cnt/run_cnt/vec_idx out)
module nor_gate_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nor_gate_exerciser_if.slave    bus
);
    localparam int              SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  sc_q;
    logic [1:0]       idx_q;
    logic             a_q, b_q;
    logic             mis_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] run_q;

    logic launch, clr_err, adv, finish, compare, miss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        clr_err = 1'b0;
        adv     = 1'b0;
        finish  = 1'b0;
        compare = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETTLE;
                    launch  = 1'b1;
                    clr_err = 1'b1;
                end
            end
            SETTLE: begin
                if (sc_q == SC_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                compare = 1'b1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    adv     = 1'b1;
                end
            end
            DONE: begin
                finish = 1'b1;
                // A continuous restart keeps err_cnt so it accumulates across runs.
                if (bus.continuous) begin
                    state_d = SETTLE;
                    launch  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // y is used raw; the settle window is what covers the cell's delay.
    assign miss = compare && (bus.y != ~(a_q | b_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sc_q    <= '0;
            idx_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            mis_q   <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;

            if (launch) begin
                idx_q <= 2'd0;
                a_q   <= 1'b0;
                b_q   <= 1'b0;
                sc_q  <= '0;
            end else if (adv) begin
                // Vector k is simply (a,b) = k in binary.
                idx_q      <= idx_q + 2'd1;
                {a_q, b_q} <= idx_q + 2'd1;
                sc_q       <= '0;
            end else if (state_q == SETTLE) begin
                sc_q <= sc_q + SC_W'(1);
            end

            if (launch)     mis_q <= 1'b0;
            else if (miss)  mis_q <= 1'b1;

            if (clr_err)    err_q <= '0;
            else if (miss)  err_q <= sat_inc(err_q);

            if (finish) begin
                pass_q <= ~mis_q;
                run_q  <= run_q + CNT_W'(1);
            end
        end
    end

    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
    assign bus.run_cnt = run_q;
    assign bus.vec_idx = idx_q;
endmodule

// File: tb/tb_nor_gate_exerciser.sv
// tb_nor_gate_exerciser
//   Directed bench for nor_gate_exerciser. dut0 uses default parameters with a
//   selectable cell model (good NOR with one-cycle delay, stuck-at-0,
//   stuck-at-1); dut1 uses CNT_W=2 with y stuck at 1 in continuous mode.
//   Cycle numbering: the edge that samples start is edge 0, cycle c follows
//   edge c; all sampling happens 1 time unit after a rising edge.
module tb_nor_gate_exerciser;
    logic clk;
    logic rst_n;
    int   mode;
    logic nor_q;
    int   n_vec;
    int   n_err;

    nor_gate_exerciser_if #(.CNT_W(8)) bus0 ();
    nor_gate_exerciser_if #(.CNT_W(2)) bus1 ();

    nor_gate_exerciser #(.SETTLE_CYCLES(2), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    nor_gate_exerciser #(.SETTLE_CYCLES(2), .CNT_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell model for dut0: good NOR with one register of delay, or stuck-at.
    always @(posedge clk) nor_q <= ~(bus0.a | bus0.b);
    assign bus0.y = (mode == 0) ? nor_q : (mode == 1) ? 1'b0 : 1'b1;
    assign bus1.y = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut0; returns positioned in cycle 1.
    task automatic start0();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    // Full run on dut0 from start to the cycle after done.
    task automatic run_one(input int e_err, input int e_pass, input int e_run);
        start0();
        repeat (12) tick();
        check("run_done13", 32'(bus0.done), 32'd1);
        tick();
        check("run_done14", 32'(bus0.done), 32'd0);
        check("run_busy14", 32'(bus0.busy), 32'd0);
        check("run_err",    32'(bus0.err_cnt), 32'(e_err));
        check("run_pass",   32'(bus0.pass), 32'(e_pass));
        check("run_cnt",    32'(bus0.run_cnt), 32'(e_run));
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_a"},    32'(bus0.a), 32'd0);
        check({tag, "_b"},    32'(bus0.b), 32'd0);
        check({tag, "_busy"}, 32'(bus0.busy), 32'd0);
        check({tag, "_done"}, 32'(bus0.done), 32'd0);
        check({tag, "_pass"}, 32'(bus0.pass), 32'd0);
        check({tag, "_err"},  32'(bus0.err_cnt), 32'd0);
        check({tag, "_run"},  32'(bus0.run_cnt), 32'd0);
        check({tag, "_vidx"}, 32'(bus0.vec_idx), 32'd0);
    endtask

    initial begin
        int k;
        int exp_run;
        n_vec = 0;
        n_err = 0;
        mode  = 0;
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus0.continuous = 1'b0;
        bus1.start = 1'b0;
        bus1.continuous = 1'b0;

        // Reset values
        tick();
        tick();
        check_reset0("rst");
        check("rst1_run", 32'(bus1.run_cnt), 32'd0);
        check("rst1_busy", 32'(bus1.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Good cell: vector sequence, timing, results
        mode = 0;
        start0();
        for (int c = 1; c <= 13; c++) begin
            k = (c > 12) ? 3 : (c - 1) / 3;
            check("seq_ab",   32'({bus0.a, bus0.b}), 32'(k));
            check("seq_vidx", 32'(bus0.vec_idx), 32'(k));
            check("seq_done", 32'(bus0.done), 32'(c == 13));
            check("seq_busy", 32'(bus0.busy), 32'd1);
            if (c < 13) tick();
        end
        tick();
        check("good_done14", 32'(bus0.done), 32'd0);
        check("good_busy",   32'(bus0.busy), 32'd0);
        check("good_pass",   32'(bus0.pass), 32'd1);
        check("good_err",    32'(bus0.err_cnt), 32'd0);
        check("good_run",    32'(bus0.run_cnt), 32'd1);

        // Stuck at 0: only idx0 mismatches
        mode = 1;
        run_one(1, 0, 2);

        // Stuck at 1: idx1..3 mismatch
        mode = 2;
        run_one(3, 0, 3);

        // start re-pulsed mid-run is ignored and does not clear err_cnt
        mode = 1;
        start0();
        repeat (4) tick();
        check("rep_err5", 32'(bus0.err_cnt), 32'd1);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        check("rep_err6",  32'(bus0.err_cnt), 32'd1);
        check("rep_vidx6", 32'(bus0.vec_idx), 32'd1);
        for (int c = 6; c <= 12; c++) begin
            check("rep_nodone", 32'(bus0.done), 32'd0);
            tick();
        end
        check("rep_done13", 32'(bus0.done), 32'd1);
        tick();
        check("rep_err",  32'(bus0.err_cnt), 32'd1);
        check("rep_pass", 32'(bus0.pass), 32'd0);
        check("rep_run",  32'(bus0.run_cnt), 32'd4);

        // Reset for one edge in cycle 7, then a clean run
        mode = 0;
        start0();
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset0("mrst");
        for (int c = 0; c < 15; c++) begin
            check("mrst_nodone", 32'(bus0.done), 32'd0);
            check("mrst_idle",   32'(bus0.busy), 32'd0);
            tick();
        end
        run_one(0, 1, 1);

        // CNT_W=2, stuck at 1, continuous for five runs
        bus1.continuous = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            check("cont_done", 32'(bus1.done), 32'((c % 13 == 0) && (c <= 65)));
            if ((c % 13 == 1) && (c > 1)) begin
                exp_run = (c / 13) % 4;
                check("cont_run",  32'(bus1.run_cnt), 32'(exp_run));
                check("cont_err",  32'(bus1.err_cnt), 32'd3);
                check("cont_pass", 32'(bus1.pass), 32'd0);
            end
            if (c == 53) bus1.continuous = 1'b0;
            if (c < 66) tick();
        end
        check("cont_busy_end", 32'(bus1.busy), 32'd0);
        check("cont_ab_end",   32'({bus1.a, bus1.b}), 32'd3);
        check("cont_vidx_end", 32'(bus1.vec_idx), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nor_gate_exerciser.md
# nor_gate_exerciser

Upstream stimulus and checking stage for the `tinytapeout` gate-level cells. It drives the two inputs of a 2-input NOR cell under test, waits a programmable settle time, samples the cell output, and compares it with the expected `~(A|B)`. It reports a pass/fail flag, a saturating mismatch count and a run count. It sits directly in front of the NOR cell and consumes the cell's output.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles each vector is held before sampling; legal range ≥1.
- `CNT_W`, default 8: width of `err_cnt` and `run_cnt`.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a run; sampled only in IDLE.
- `continuous` in 1: sampled in DONE; when high, the next run starts automatically.
- `y` in 1: output of the NOR cell under test.
- `a` out 1: NOR input A, registered.
- `b` out 1: NOR input B, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of each run.
- `pass` out 1: result of the most recent completed run (1 = no mismatch).
- `err_cnt` out CNT_W: saturating mismatch count.
- `run_cnt` out CNT_W: completed runs, wraps modulo 2^CNT_W.
- `vec_idx` out 2: index of the vector currently applied.

## Operation
- States:
  - IDLE
  - SETTLE: hold the current vector; a settle counter counts 0..SETTLE_CYCLES-1.
  - SAMPLE: compare once.
  - DONE
- Vector order, as (a,b) with expected y:
  - idx0 = (0,0), expect 1
  - idx1 = (0,1), expect 0
  - idx2 = (1,0), expect 0
  - idx3 = (1,1), expect 0
- IDLE + `start`=1 on an edge:
  - `a`,`b` ← vector 0 and `vec_idx` ← 0.
  - `err_cnt` ← 0 and the per-run mismatch flag ← 0.
  - Settle counter ← 0; go to SETTLE.
- IDLE + `start`=0: stay in IDLE; `a`,`b` hold their last value.
- SETTLE:
  - The counter increments each cycle.
  - When the counter = SETTLE_CYCLES-1, the next state is SAMPLE.
- SAMPLE edge:
  - If `y` ≠ expected: `err_cnt` increments unless it is all-ones (saturate), and the per-run mismatch flag ← 1.
  - If `vec_idx`<3: advance `vec_idx` and `a`/`b` to the next vector, clear the settle counter, go to SETTLE.
  - If `vec_idx`=3: go to DONE.
- DONE (one cycle):
  - `done`=1 during this cycle.
  - On the exiting edge: `pass` ← ~mismatch flag and `run_cnt` increments, wrapping.
  - If `continuous`=1: restart exactly as a `start` from IDLE, except that `err_cnt` is NOT cleared. It accumulates across continuous runs; the per-run mismatch flag is still cleared.
  - If `continuous`=0: go to IDLE.
- `start` is ignored whenever `busy`=1.
- Deasserting `continuous` mid-run: the current run completes, then the block returns to IDLE.
- The comparison uses `y` exactly as sampled at the SAMPLE edge. No synchronizer is applied; the settle time is the mechanism that covers the cell's propagation delay.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State ← IDLE.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `run_cnt`=0, `vec_idx`=0.
  - All counters and the mismatch flag are cleared.
- Reset mid-run: IDLE after that edge; no `done` pulse; `pass` and `run_cnt` are not updated (they read 0).
- Per vector: SETTLE_CYCLES cycles in SETTLE + 1 cycle in SAMPLE.
- Taking the start edge as edge 0:
  - `a`/`b` show vector 0 from cycle 1.
  - Vector k is applied from cycle 1 + k·(SETTLE_CYCLES+1).
  - `done` is high in cycle 4·(SETTLE_CYCLES+1)+1, which is cycle 13 at the default.
  - `pass` and `run_cnt` are updated from the following cycle.
- Continuous mode: the next run's vector 0 appears in the cycle after `done`. The run period is 4·(SETTLE_CYCLES+1)+1 cycles.
- `busy` goes high in cycle 1 and goes low in the cycle after `done` (non-continuous).

## Test plan
- Correct NOR model with 1-cycle delay, default params, `start` pulse:
  - `a`/`b` sequence 00,01,10,11, each held 3 cycles.
  - `done` in cycle 13; then `pass`=1, `err_cnt`=0, `run_cnt`=1, `busy`=0.
- `y` stuck at 0: mismatch only on idx0; `err_cnt`=1, `pass`=0.
- `y` stuck at 1: mismatches on idx1–3; `err_cnt`=3, `pass`=0.
- CNT_W=2, `y` stuck at 1, `continuous`=1 for 5 runs:
  - `err_cnt` saturates at 3 and stays 3.
  - `run_cnt` reads 1,2,3,0,1.
  - `done` pulses every 13 cycles.
- `start` re-pulsed in cycle 5 of a run: ignored; `done` still only in cycle 13; `err_cnt` is not cleared.
- `rst_n`=0 for one edge in cycle 7:
  - All outputs return to their reset values and no `done` pulse occurs.
  - A new `start` then yields a clean run with `pass`=1.
